time_sync_scheduler: RTL and testbench

//  Timed command scheduler that drives the time_sync control port (igp_timecmd_*).

---
 rtl/time_sync_pkg.sv | 30 +++
 rtl/time_sync_scheduler_fifo.sv | 58 +++++
 rtl/time_sync_scheduler.sv | 135 +++++++++++++
 tb/tb_time_sync_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_sync_pkg.sv
// Shared definitions for the time_sync command scheduler.
//   sync_type_e   : sync-type codes carried in cmd[2:0]
//   CMD_*         : bit positions inside the 16-bit command word
//   sched_state_e : scheduler FSM encoding
package time_sync_pkg;

    typedef enum logic [2:0] {
        SYNC_STOP     = 3'd0,
        SYNC_ONESHOT  = 3'd1,
        SYNC_PERIODIC = 3'd2,
        SYNC_GATED    = 3'd3,
        SYNC_PPS      = 3'd4,
        SYNC_SYSREF   = 3'd5,
        SYNC_EXTERNAL = 3'd6,
        SYNC_FREERUN  = 3'd7
    } sync_type_e;

    localparam int CMD_WIDTH    = 16;
    localparam int CMD_GEN_EN   = 3;
    localparam int CMD_TYPE_MSB = 2;
    localparam int CMD_TYPE_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_ISSUE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/time_sync_scheduler_fifo.sv
// sched_fifo: synchronous FIFO holding scheduler entries.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous clear of pointers and level
//   wr_en/wr_data : push (ignored when full)
//   rd_en/rd_data : pop (ignored when empty); rd_data shows the head combinationally
//   level/full/empty : occupancy status
module sched_fifo #(
    parameter int WIDTH      = 65,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_wr, do_rd;

    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (!do_wr && do_rd) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; only pointer-covered slots are ever read.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/time_sync_scheduler.sv
// time_sync_scheduler: releases queued {timestamp, command} entries to the
// time_sync control port when the timer reaches the timestamp (or at once for
// immediate entries). Entries found more than LATE_WINDOW ticks past due are
// dropped and counted.
//   igp_clk, igp_reset_n      : clock, async active-low reset
//   timer_now, timer_valid    : running timer
//   sched_*                   : queue write port (valid/ready)
//   flush                     : clear queue and any pending issue
//   timecmd_valid/data/ready  : command port towards time_sync
//   stat_*                    : occupancy, issue/late pulses, saturating late count
module time_sync_scheduler
    import time_sync_pkg::*;
#(
    parameter int TIMER_WIDTH = 48,
    parameter int DEPTH_LOG2  = 2,
    parameter int LATE_WINDOW = 1024,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   igp_clk,
    input  logic                   igp_reset_n,
    input  logic [TIMER_WIDTH-1:0] timer_now,
    input  logic                   timer_valid,
    input  logic                   sched_valid,
    output logic                   sched_ready,
    input  logic [TIMER_WIDTH-1:0] sched_ts,
    input  logic [CMD_WIDTH-1:0]   sched_cmd,
    input  logic                   sched_immediate,
    input  logic                   flush,
    output logic                   timecmd_valid,
    output logic [CMD_WIDTH-1:0]   timecmd_data,
    input  logic                   timecmd_ready,
    output logic [DEPTH_LOG2:0]    stat_level,
    output logic                   stat_issued,
    output logic                   stat_late,
    output logic [CNT_WIDTH-1:0]   stat_late_cnt
);
    // Entry layout: {immediate, cmd, ts}
    localparam int ENTRY_W = TIMER_WIDTH + CMD_WIDTH + 1;

    logic [ENTRY_W-1:0]     wr_entry, head;
    logic [TIMER_WIDTH-1:0] head_ts, delta;
    logic [CMD_WIDTH-1:0]   head_cmd;
    logic                   head_imm, head_due, head_late, past_ts;
    logic                   full, empty, pop, late_drop;
    logic                   due_q, late_q;
    logic [CNT_WIDTH-1:0]   late_cnt_q;
    sched_state_e           state_q, state_d;

    assign wr_entry    = {sched_immediate, sched_cmd, sched_ts};
    assign sched_ready = !full && !flush;

    sched_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (igp_clk),
        .rst_n   (igp_reset_n),
        .flush   (flush),
        .wr_en   (sched_valid && sched_ready),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .level   (stat_level),
        .full    (full),
        .empty   (empty)
    );

    assign head_ts  = head[TIMER_WIDTH-1:0];
    assign head_cmd = head[TIMER_WIDTH +: CMD_WIDTH];
    assign head_imm = head[ENTRY_W-1];

    // Modular difference: a clear MSB means the timer is at or past the
    // timestamp, which stays correct across timer wrap within half range.
    assign delta     = timer_now - head_ts;
    assign past_ts   = timer_valid && !delta[TIMER_WIDTH-1];
    assign head_due  = head_imm || past_ts;
    assign head_late = !head_imm && past_ts && (delta > TIMER_WIDTH'(LATE_WINDOW));

    always_ff @(posedge igp_clk or negedge igp_reset_n) begin
        if (!igp_reset_n) begin
            state_q    <= ST_IDLE;
            due_q      <= 1'b0;
            late_q     <= 1'b0;
            late_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_EVAL) begin
                due_q  <= head_due;
                late_q <= head_late;
            end
            if (late_drop && (late_cnt_q != '1)) late_cnt_q <= late_cnt_q + 1'b1;
        end
    end

    // Flush overrides every transition, so it also suppresses pops and drops.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        late_drop = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (!empty) state_d = ST_EVAL;
                ST_EVAL:   state_d = ST_DECIDE;
                ST_DECIDE: begin
                    if (late_q) begin
                        pop       = 1'b1;
                        late_drop = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (due_q) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_EVAL;
                    end
                end
                ST_ISSUE: begin
                    if (timecmd_ready) begin
                        pop     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The offer is withdrawn in the flush cycle so no handshake can slip past a flush.
    assign timecmd_valid = (state_q == ST_ISSUE) && !flush;
    assign timecmd_data  = timecmd_valid ? head_cmd : '0;
    assign stat_issued   = timecmd_valid && timecmd_ready;
    assign stat_late     = late_drop;
    assign stat_late_cnt = late_cnt_q;

endmodule

// File: tb/tb_time_sync_scheduler.sv
module tb_time_sync_scheduler;
    localparam int TW = 48;
    localparam int LW = 1024;

    logic          igp_clk = 1'b0;
    logic          igp_reset_n;
    logic [TW-1:0] timer_now;
    logic          timer_valid;
    logic          sched_valid;
    logic          sched_ready;
    logic [TW-1:0] sched_ts;
    logic [15:0]   sched_cmd;
    logic          sched_immediate;
    logic          flush;
    logic          timecmd_valid;
    logic [15:0]   timecmd_data;
    logic          timecmd_ready;
    logic [2:0]    stat_level;
    logic          stat_issued;
    logic          stat_late;
    logic [7:0]    stat_late_cnt;

    int checks = 0;
    int errors = 0;
    int exp_late_cnt = 0;

    time_sync_scheduler #(.TIMER_WIDTH(TW), .DEPTH_LOG2(2), .LATE_WINDOW(LW), .CNT_WIDTH(8)) dut (
        .igp_clk(igp_clk), .igp_reset_n(igp_reset_n), .timer_now(timer_now),
        .timer_valid(timer_valid), .sched_valid(sched_valid), .sched_ready(sched_ready),
        .sched_ts(sched_ts), .sched_cmd(sched_cmd), .sched_immediate(sched_immediate),
        .flush(flush), .timecmd_valid(timecmd_valid), .timecmd_data(timecmd_data),
        .timecmd_ready(timecmd_ready), .stat_level(stat_level), .stat_issued(stat_issued),
        .stat_late(stat_late), .stat_late_cnt(stat_late_cnt)
    );

    always #5 igp_clk = ~igp_clk;

    task automatic present(input bit imm, input logic [TW-1:0] ts, input logic [15:0] cmd);
        sched_valid = 1'b1; sched_immediate = imm; sched_ts = ts; sched_cmd = cmd;
    endtask

    task automatic check_reset_outputs(input string tag);
        if ({timecmd_valid, timecmd_data, stat_level, stat_issued, stat_late, stat_late_cnt} !== '0) begin
            errors++;
            $display("FAIL %s outputs got v=%b d=%h lvl=%0d iss=%b late=%b cnt=%0d exp all 0",
                     tag, timecmd_valid, timecmd_data, stat_level, stat_issued, stat_late, stat_late_cnt);
        end
        checks++;
        if (sched_ready !== 1'b1) begin
            errors++; $display("FAIL %s sched_ready got %b exp 1", tag, sched_ready);
        end
        checks++;
    endtask

    task automatic test_reset();
        igp_reset_n = 1'b0; timer_now = '0; timer_valid = 1'b1; sched_valid = 1'b0;
        sched_ts = '0; sched_cmd = '0; sched_immediate = 1'b0; flush = 1'b0; timecmd_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge igp_clk); igp_reset_n = 1'b1;
        exp_late_cnt = 0;
    endtask

    task automatic test_immediate();
        @(negedge igp_clk); present(1'b1, '0, 16'h0001); #1;
        if (sched_ready !== 1'b1) begin errors++; $display("FAIL imm_ready got %b exp 1", sched_ready); end
        checks++;
        @(negedge igp_clk); sched_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (timecmd_valid !== 1'b0) begin errors++; $display("FAIL imm_early k=%0d got %b exp 0", k, timecmd_valid); end
            checks++;
            @(negedge igp_clk);
        end
        #1;
        if (timecmd_valid !== 1'b1 || timecmd_data !== 16'h0001) begin
            errors++; $display("FAIL imm_issue got v=%b d=%h exp v=1 d=0001", timecmd_valid, timecmd_data);
        end
        checks++;
        timecmd_ready = 1'b1; #1;
        if (stat_issued !== 1'b1) begin errors++; $display("FAIL imm_issued got %b exp 1", stat_issued); end
        checks++;
        @(negedge igp_clk); timecmd_ready = 1'b0; #1;
        if (timecmd_valid !== 1'b0 || stat_level !== 3'd0 || stat_issued !== 1'b0) begin
            errors++; $display("FAIL imm_after got v=%b lvl=%0d iss=%b exp 0 0 0", timecmd_valid, stat_level, stat_issued);
        end
        checks++;
    endtask

    // Ramp the timer one tick per cycle until the command appears; returns the
    // timer value that was applied at the edge that made it visible.
    task automatic ramp_until_valid(input int budget, output bit seen, output logic [TW-1:0] at_now, output int lates);
        seen = 1'b0; at_now = '0; lates = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            #1;
            if (stat_late) lates++;
            if (timecmd_valid) begin seen = 1'b1; at_now = timer_now; end
            else timer_now = timer_now + 1'b1;
            if (!seen) @(negedge igp_clk);
        end
    endtask

    task automatic handshake(input string tag);
        timecmd_ready = 1'b1; #1;
        if (stat_issued !== 1'b1) begin errors++; $display("FAIL %s issued got %b exp 1", tag, stat_issued); end
        checks++;
        @(negedge igp_clk); timecmd_ready = 1'b0;
    endtask

    task automatic test_timed();
        bit seen; logic [TW-1:0] at_now; int lates;
        @(negedge igp_clk); timer_now = 48'd900; present(1'b0, 48'd1000, 16'h0012);
        @(negedge igp_clk); sched_valid = 1'b0;
        ramp_until_valid(300, seen, at_now, lates);
        if (!seen) begin errors++; $display("FAIL timed_timeout got no valid exp valid"); end
        checks++;
        if (at_now < 48'd1000 || at_now > 48'd1004) begin
            errors++; $display("FAIL timed_window got now=%0d exp 1000..1004", at_now);
        end
        checks++;
        if (timecmd_data !== 16'h0012) begin errors++; $display("FAIL timed_data got %h exp 0012", timecmd_data); end
        checks++;
        handshake("timed");
    endtask

    task automatic test_late();
        int pulses = 0; bit saw = 1'b0;
        @(negedge igp_clk); timer_now = 48'd5000; present(1'b0, 48'd100, 16'h0005);
        @(negedge igp_clk); sched_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (stat_late) pulses++;
            if (timecmd_valid) saw = 1'b1;
            @(negedge igp_clk);
        end
        exp_late_cnt++;
        if (saw !== 1'b0) begin errors++; $display("FAIL late_valid got 1 exp 0"); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL late_pulses got %0d exp 1", pulses); end
        checks++;
        if (stat_late_cnt !== 8'(exp_late_cnt) || stat_level !== 3'd0) begin
            errors++; $display("FAIL late_cnt got cnt=%0d lvl=%0d exp cnt=%0d lvl=0", stat_late_cnt, stat_level, exp_late_cnt);
        end
        checks++;
    endtask

    task automatic test_wrap();
        bit seen; logic [TW-1:0] at_now, d; int lates;
        @(negedge igp_clk); timer_now = 48'hFFFF_FFFF_FFF0; present(1'b0, 48'h10, 16'h000B);
        @(negedge igp_clk); sched_valid = 1'b0;
        ramp_until_valid(100, seen, at_now, lates);
        d = at_now - 48'h10;
        if (!seen) begin errors++; $display("FAIL wrap_timeout got no valid exp valid"); end
        checks++;
        if (d > 48'd4) begin errors++; $display("FAIL wrap_window got now=%h exp 10..14", at_now); end
        checks++;
        if (lates != 0 || stat_late_cnt !== 8'(exp_late_cnt)) begin
            errors++; $display("FAIL wrap_late got pulses=%0d cnt=%0d exp 0 %0d", lates, stat_late_cnt, exp_late_cnt);
        end
        checks++;
        if (timecmd_data !== 16'h000B) begin errors++; $display("FAIL wrap_data got %h exp 000b", timecmd_data); end
        checks++;
        handshake("wrap");
    endtask

    task automatic test_back_to_back();
        logic [15:0] cmds [4] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        logic [15:0] got [$];
        timer_now = 48'd2000; timecmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge igp_clk); present(1'b1, '0, cmds[i]); #1;
            if (sched_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d got %b exp 1", i, sched_ready); end
            checks++;
        end
        @(negedge igp_clk); present(1'b1, '0, 16'h0505);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (sched_ready !== 1'b0 || stat_level !== 3'd4) begin
                errors++; $display("FAIL b2b_full%0d got rdy=%b lvl=%0d exp 0 4", i, sched_ready, stat_level);
            end
            checks++;
            @(negedge igp_clk);
        end
        sched_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (timecmd_valid !== 1'b1 || timecmd_data !== 16'h0101) begin
                errors++; $display("FAIL b2b_hold%0d got v=%b d=%h exp 1 0101", i, timecmd_valid, timecmd_data);
            end
            checks++;
            @(negedge igp_clk);
        end
        timecmd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (stat_issued) got.push_back(timecmd_data);
            @(negedge igp_clk);
        end
        timecmd_ready = 1'b0;
        if (got.size() != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", got.size()); end
        checks++;
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            if (got[i] !== cmds[i]) begin errors++; $display("FAIL b2b_order%0d got %h exp %h", i, got[i], cmds[i]); end
            checks++;
        end
        #1;
        if (stat_level !== 3'd0) begin errors++; $display("FAIL b2b_level got %0d exp 0", stat_level); end
        checks++;
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        timecmd_ready = 1'b0;
        @(negedge igp_clk); present(1'b1, '0, 16'h0707);
        @(negedge igp_clk); sched_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1; if (timecmd_valid) seen = 1'b1; else @(negedge igp_clk);
        end
        if (!seen) begin errors++; $display("FAIL flush_setup got no valid exp valid"); end
        checks++;
        @(negedge igp_clk); flush = 1'b1; present(1'b1, '0, 16'h0808); #1;
        if (sched_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", sched_ready); end
        checks++;
        @(negedge igp_clk); flush = 1'b0; sched_valid = 1'b0; #1;
        if (timecmd_valid !== 1'b0 || stat_level !== 3'd0 || stat_late_cnt !== 8'(exp_late_cnt)) begin
            errors++; $display("FAIL flush_clear got v=%b lvl=%0d cnt=%0d exp 0 0 %0d",
                               timecmd_valid, stat_level, stat_late_cnt, exp_late_cnt);
        end
        checks++;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge igp_clk); #1; if (timecmd_valid) seen = 1'b1;
        end
        if (seen) begin errors++; $display("FAIL flush_residue got valid exp none"); end
        checks++;
    endtask

    // Random mix of immediate, future and hopelessly-late entries. The model
    // only needs the release rules: non-late entries come out in write order,
    // never before their timestamp; late ones are dropped and counted.
    typedef struct { logic [15:0] cmd; logic [TW-1:0] ts; bit imm; } ent_t;

    task automatic test_random();
        ent_t exp_q [$];
        ent_t e;
        int n_wr = 0, late_model = 0, late_seen = 0, kind = 0;
        bit done = 1'b0;
        logic [TW-1:0] d;
        @(negedge igp_clk); igp_reset_n = 1'b0;
        @(negedge igp_clk); igp_reset_n = 1'b1;
        timer_now = 48'd100000; timer_valid = 1'b1;
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            @(negedge igp_clk);
            timer_now = timer_now + 1'b1;
            timecmd_ready = 1'($urandom_range(0, 1));
            if (n_wr < 40 && $urandom_range(0, 2) != 0) begin
                kind = $urandom_range(0, 3);
                e.cmd = 16'($urandom);
                e.imm = (kind == 0);
                e.ts  = (kind == 1) ? timer_now - 48'd5000 : timer_now + 48'($urandom_range(0, 60));
                present(e.imm, e.ts, e.cmd);
            end else begin
                sched_valid = 1'b0;
            end
            #1;
            if (sched_valid && sched_ready) begin
                n_wr++;
                if (kind == 1) late_model++; else exp_q.push_back(e);
            end
            if (stat_late) late_seen++;
            if (stat_issued) begin
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra got %h exp none", timecmd_data);
                    checks++;
                end else begin
                    if (timecmd_data !== exp_q[0].cmd) begin
                        errors++; $display("FAIL rnd_data got %h exp %h", timecmd_data, exp_q[0].cmd);
                    end
                    checks++;
                    d = timer_now - exp_q[0].ts;
                    if (!exp_q[0].imm && (d[TW-1] || d > 48'(LW))) begin
                        errors++; $display("FAIL rnd_time got now=%0d exp >= ts %0d", timer_now, exp_q[0].ts);
                    end
                    checks++;
                    void'(exp_q.pop_front());
                end
            end
            done = (n_wr == 40) && (exp_q.size() == 0) && (stat_level == 3'd0) && !timecmd_valid;
        end
        sched_valid = 1'b0; timecmd_ready = 1'b0;
        repeat (6) @(negedge igp_clk);
        #1;
        if (!done) begin errors++; $display("FAIL rnd_timeout got wr=%0d pend=%0d exp 40 0", n_wr, exp_q.size()); end
        checks++;
        if (late_seen != late_model || stat_late_cnt !== 8'(late_model)) begin
            errors++; $display("FAIL rnd_late got pulses=%0d cnt=%0d exp %0d", late_seen, stat_late_cnt, late_model);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        bit saw = 1'b0;
        timecmd_ready = 1'b0; timer_valid = 1'b0;
        @(negedge igp_clk); present(1'b0, timer_now - 48'd3, 16'h0033);
        @(negedge igp_clk); sched_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge igp_clk); #1; if (timecmd_valid || stat_late) saw = 1'b1;
        end
        if (saw || stat_level !== 3'd1) begin
            errors++; $display("FAIL tv_hold got activity=%b lvl=%0d exp 0 1", saw, stat_level);
        end
        checks++;
        @(negedge igp_clk); #2 igp_reset_n = 1'b0; #1;
        check_reset_outputs("reset_mid");
        @(negedge igp_clk); igp_reset_n = 1'b1; timer_valid = 1'b1;
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_timed();
        test_late();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
